// File: rtl/code_expander.sv
// Bin-code expander: buffers 2-bit bin codes in a small FIFO and presents the
// head code's representative value and inclusive bounds, with per-bin hit counters.
module code_expander #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [1:0]  code_in_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [3:0]  data_out_o,
    output logic [3:0]  out_lo_o,
    output logic [3:0]  out_hi_o,
    input  logic        clr_i,
    output logic [31:0] bin_cnt_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q;
    logic [7:0]    cnt_q [4];
    logic [7:0]    cnt_d [4];

    logic          full;
    logic          push;
    logic          pop;
    logic [1:0]    head;

    // ready_q keeps in_ready low until the first edge after reset release
    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign in_ready_o  = ready_q & ~full;
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign head        = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 2'b00;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= 1'b1;
            if (push) begin
                mem_q[wr_ptr_q] <= code_in_i;
            end
        end
    end

    always_comb begin
        data_out_o = 4'd0;
        out_lo_o   = 4'd0;
        out_hi_o   = 4'd0;
        if (out_valid_o) begin
            case (head)
                2'b00: begin data_out_o = 4'd2;  out_lo_o = 4'd0;  out_hi_o = 4'd4;  end
                2'b01: begin data_out_o = 4'd6;  out_lo_o = 4'd5;  out_hi_o = 4'd8;  end
                2'b10: begin data_out_o = 4'd10; out_lo_o = 4'd9;  out_hi_o = 4'd12; end
                default: begin data_out_o = 4'd14; out_lo_o = 4'd13; out_hi_o = 4'd15; end
            endcase
        end
    end

    // Clear wins over a same-cycle increment; counters stick at 255
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (clr_i) begin
            for (int i = 0; i < 4; i++) begin
                cnt_d[i] = 8'd0;
            end
        end else if (pop && (cnt_q[head] != 8'hFF)) begin
            cnt_d[head] = cnt_q[head] + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bin_cnt_o = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};

endmodule
